// File: rtl/gray_decoder.sv
// Gray-code receiver: decodes a sampled gray word to binary and classifies each
// new sample against the previous one as hold, +1, -1 (with wrap flags) or an illegal jump.
module gray_decoder #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Output,
    output logic             Valid,
    output logic             Up,
    output logic             Down,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] STEP_FWD = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_BWD = '1;
    localparam logic [WIDTH-1:0] CODE_TOP = '1;
    localparam logic [WIDTH-1:0] CODE_BOT = '0;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t           state, state_nxt;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] out_p0, out_nxt;
    logic             vld_p0, vld_nxt;
    logic             up_p0, up_nxt;
    logic             down_p0, down_nxt;
    logic             ovf_p0, ovf_nxt;
    logic             unf_p0, unf_nxt;
    logic             err_p0, err_nxt;

    assign bin   = gray2bin(Gray);
    // Modulo-2^WIDTH distance from the last accepted position.
    assign delta = bin - out_p0;

    // Sampling edge: everything visible on the outputs is registered here.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            out_p0  <= '0;
            vld_p0  <= 1'b0;
            up_p0   <= 1'b0;
            down_p0 <= 1'b0;
            ovf_p0  <= 1'b0;
            unf_p0  <= 1'b0;
            err_p0  <= 1'b0;
        end else begin
            state   <= state_nxt;
            out_p0  <= out_nxt;
            vld_p0  <= vld_nxt;
            up_p0   <= up_nxt;
            down_p0 <= down_nxt;
            ovf_p0  <= ovf_nxt;
            unf_p0  <= unf_nxt;
            err_p0  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (En) begin
            case (state)
                IDLE:    state_nxt = TRACK;
                TRACK:   if (delta != CODE_BOT && delta != STEP_FWD && delta != STEP_BWD)
                             state_nxt = FAULT;
                FAULT:   state_nxt = FAULT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_nxt  = out_p0;
        vld_nxt  = vld_p0;
        up_nxt   = 1'b0;
        down_nxt = 1'b0;
        ovf_nxt  = ovf_p0;
        unf_nxt  = unf_p0;
        err_nxt  = err_p0;
        if (En) begin
            case (state)
                IDLE: begin
                    out_nxt = bin;
                    vld_nxt = 1'b1;
                end
                TRACK: begin
                    if (delta == STEP_FWD) begin
                        out_nxt = bin;
                        up_nxt  = 1'b1;
                        if (out_p0 == CODE_TOP) ovf_nxt = 1'b1;
                    end else if (delta == STEP_BWD) begin
                        out_nxt  = bin;
                        down_nxt = 1'b1;
                        if (out_p0 == CODE_BOT) unf_nxt = 1'b1;
                    end else if (delta != CODE_BOT) begin
                        out_nxt = bin;
                        err_nxt = 1'b1;
                    end
                end
                FAULT: out_nxt = bin;
                default: ;
            endcase
        end
    end

    assign Output    = out_p0;
    assign Valid     = vld_p0;
    assign Up        = up_p0;
    assign Down      = down_p0;
    assign Overflow  = ovf_p0;
    assign Underflow = unf_p0;
    assign Error     = err_p0;

endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
- Receiving end of the gray counter: samples a WIDTH-bit gray-code word, converts it to binary, and tracks the code stream.
- Each sampled code is checked as a legal single step (hold, +1 or −1 modulo 2^WIDTH).
- Reports direction pulses, wrap-around (Overflow/Underflow) and illegal jumps (Error).
- Sits downstream of gray-coded counters and position sources, including signals crossing from another clock domain once synchronised.

Parameters:
- WIDTH, 3, bit width of the gray input and binary output (≥2).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset; clears all state immediately.
- En  input  1  sample enable; Gray is sampled only on rising Clk with En=1.
- Gray  input  WIDTH  gray-coded input word.
- Output  output  WIDTH  registered binary value of the last sampled code.
- Valid  output  1  high once at least one sample has been taken since reset.
- Up  output  1  one-cycle pulse: last sample was a +1 step.
- Down  output  1  one-cycle pulse: last sample was a −1 step.
- Overflow  output  1  sticky: a +1 step wrapped from 2^WIDTH−1 to 0.
- Underflow  output  1  sticky: a −1 step wrapped from 0 to 2^WIDTH−1.
- Error  output  1  sticky: an illegal step was sampled.

Behaviour:
- Decode (combinational):
  - bin[WIDTH−1] = Gray[WIDTH−1].
  - bin[i] = bin[i+1] ^ Gray[i], for i = WIDTH−2 down to 0.
- Reset (asynchronous, any time, including mid-stream):
  - Output=0; Valid, Up, Down, Overflow, Underflow and Error all 0.
  - State returns to IDLE.
- State machine: IDLE, TRACK, FAULT.
- IDLE, on En=1:
  - Output<=bin, Valid<=1, go to TRACK.
  - No Up/Down pulse, no flag change.
  - This first sample is the baseline.
- TRACK, on En=1:
  - delta = (bin − Output) mod 2^WIDTH, computed in WIDTH bits.
  - delta=0: hold. Output unchanged, no pulse.
  - delta=1: Output<=bin, Up<=1.
  - delta=1 and Output was 2^WIDTH−1: additionally Overflow<=1.
  - delta=2^WIDTH−1: Output<=bin, Down<=1.
  - delta=2^WIDTH−1 and Output was 0: additionally Underflow<=1.
  - Any other delta: Output<=bin, Error<=1, go to FAULT, no pulse.
- FAULT, on En=1:
  - Output<=bin, so decoding continues.
  - Up and Down stay 0; Overflow and Underflow are frozen.
  - Only Reset leaves FAULT.
- En=0 cycle: all registers hold except Up/Down, which return to 0.
- Up and Down are never high together. Each is high for exactly the cycle after the qualifying sampling edge.
- Latency: Output, pulses and flags update on the same edge that samples Gray (1-cycle registered latency).
- Overflow, Underflow and Error are sticky until Reset; re-triggering has no further effect.
- Gray is assumed stable around the sampling edge; synchronisation is the upstream block's responsibility.

Test Plan:
- Reset behaviour: assert Reset asynchronously mid-cycle → all outputs 0 before the next Clk edge. Release, then hold En=0 for 3 cycles → Valid stays 0.
- Baseline and forward count (WIDTH=3):
  - Stimulus: En=1, Gray = 000, 001, 011, 010, 110, 111, 101, 100, 000.
  - Output must go 0,1,2,3,4,5,6,7,0.
  - Up must pulse on samples 2–9; Down stays 0.
  - Overflow must set on the 100→000 sample; Error stays 0.
- Reverse count: baseline Gray=000, then 100, 101.
  - Output must go 0,7,6.
  - Down must pulse twice; Underflow must set on the 000→100 sample; Overflow stays 0.
- Hold and enable gating:
  - Repeated Gray=011 with En=1 → Output stays 2, no pulses.
  - Change Gray to 010 with En=0 → no change.
  - Raise En → Output=3, one Up pulse.
- Illegal jump:
  - From Output=1 (Gray 001), sample Gray=110 (bin 4) → Error=1, Output=4, no pulse.
  - Then 111 → Output=5, still no Up.
  - Assert Reset → Error=0, state IDLE.
- Reset during stream: after Overflow=1 in the middle of a count, pulse Reset → Overflow=0, Valid=0. The next sample is a baseline only, with no pulse.
